// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - per-bit synchronizer, debounce counter, edge strobes and sticky edge flags
// A level is accepted once s2 has disagreed with the output for DB_CYCLES consecutive edges.
module pio_in_debounce #(
  parameter int W         = 8,
  parameter int DB_CYCLES = 250000
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic [W-1:0] raw_in,
  input  logic [W-1:0] edge_clr,
  output logic [W-1:0] pio_0_in_port,
  output logic [W-1:0] rise_stb,
  output logic [W-1:0] fall_stb,
  output logic [W-1:0] edge_cap,
  output logic         irq
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  generate
    if (DB_CYCLES < 2) begin : g_bad_param
      $error("pio_in_debounce: DB_CYCLES must be at least 2");
    end
  endgenerate

  logic [W-1:0]         s1_q;
  logic [W-1:0]         s2_q;
  logic [W-1:0][CW-1:0] cnt_q;
  logic [W-1:0][CW-1:0] cnt_d;
  logic [W-1:0]         level_q;
  logic [W-1:0]         level_d;
  logic [W-1:0]         rise_q;
  logic [W-1:0]         rise_d;
  logic [W-1:0]         fall_q;
  logic [W-1:0]         fall_d;
  logic [W-1:0]         edge_cap_q;
  logic [W-1:0]         edge_cap_d;
  logic                 irq_q;
  logic                 irq_d;
  logic [W-1:0]         load;

  // Each bit has its own counter; the comparison against the output keeps bits independent.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    load    = '0;
    for (int i = 0; i < W; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        load[i]    = 1'b1;
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // A new transition on the same edge as a clear keeps the flag set.
  always_comb begin
    rise_d     = load & s2_q;
    fall_d     = load & ~s2_q;
    edge_cap_d = (edge_cap_q & ~edge_clr) | load;
    irq_d      = |edge_cap_q;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= raw_in;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end

  assign pio_0_in_port = level_q;
  assign rise_stb      = rise_q;
  assign fall_stb      = fall_q;
  assign edge_cap      = edge_cap_q;
  assign irq           = irq_q;

endmodule
